// File: rtl/l1d_wb_pkg.sv
// Shared types and constants for the L1D writeback buffer.
// Line geometry here must match the B / PADDR_BITS parameters of the top.
package l1d_wb_pkg;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned PADDR_W    = 22;
    localparam int unsigned LINE_W     = 8 * LINE_BYTES;
    localparam int unsigned LINE_OFF   = $clog2(LINE_BYTES);

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [LINE_W-1:0]  line;
        logic               valid;
    } wb_entry_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_FWD,
        R_REQ,
        R_WAIT,
        R_RESP
    } rd_state_t;

    // Byte offset within the line is ignored.
    function automatic logic line_match(input logic [PADDR_W-1:0] a,
                                        input logic [PADDR_W-1:0] b);
        return a[PADDR_W-1:LINE_OFF] == b[PADDR_W-1:LINE_OFF];
    endfunction

endpackage

// File: rtl/l1d_wb_cam_fifo.sv
// Writeback FIFO with a parallel line-address search, in-place line update,
// tail push and head pop. At most one entry can match since evictions coalesce.
module l1d_wb_cam_fifo
    import l1d_wb_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned IdxW  = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               upd_i,
    input  logic               pop_i,
    input  logic [PADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic               hit_o,
    output logic [IdxW-1:0]    hit_idx_o,
    output logic [LINE_W-1:0]  hit_line_o,
    output wb_entry_t          head_o,
    output logic [IdxW-1:0]    head_idx_o,
    output logic               full_o
);

    localparam int unsigned CntW = IdxW + 1;

    wb_entry_t         mem_q [Depth];
    wb_entry_t         mem_d [Depth];
    logic [IdxW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (mem_q[i].valid && line_match(mem_q[i].paddr, addr_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IdxW'(i);
            end
        end
    end

    assign hit_line_o = mem_q[hit_idx_o].line;
    assign head_o     = mem_q[rd_ptr_q];
    assign head_idx_o = rd_ptr_q;
    assign full_o     = (cnt_q == CntW'(Depth));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (upd_i) begin
            mem_d[hit_idx_o].line = line_i;
        end
        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{paddr: addr_i, line: line_i, valid: 1'b1};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/l1d_writeback_buffer.sv
// L1D-to-L2 writeback buffer: read-miss FSM, L2 request arbitration, registered outputs.
// Define L1D_WB_FORWARD_EN to answer reads that hit a parked eviction locally.
module l1d_writeback_buffer
    import l1d_wb_pkg::*;
#(
    parameter int unsigned B          = LINE_BYTES,
    parameter int unsigned PADDR_BITS = PADDR_W,
    parameter int unsigned WB_DEPTH   = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  hc_valid_in,
    output logic                  hc_ready_out,
    input  logic [PADDR_BITS-1:0] hc_addr_in,
    input  logic [8*B-1:0]        hc_value_in,
    input  logic                  hc_we_in,
    output logic                  hc_valid_out,
    input  logic                  hc_ready_in,
    output logic [PADDR_BITS-1:0] hc_addr_out,
    output logic [8*B-1:0]        hc_value_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [8*B-1:0]        lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [8*B-1:0]        lc_value_in
);

    localparam int unsigned IdxW = $clog2(WB_DEPTH);

    rd_state_t          state_q, state_d;
    logic               live_q;
    logic [PADDR_W-1:0] rd_addr_q;
    logic [PADDR_W-1:0] resp_addr_q;
    logic [LINE_W-1:0]  resp_line_q;
    logic               lc_valid_q, lc_we_q;
    logic [PADDR_W-1:0] lc_addr_q;
    logic [LINE_W-1:0]  lc_value_q;

    logic               hit, full;
    logic [IdxW-1:0]    hit_idx, head_idx;
    logic [LINE_W-1:0]  hit_line;
    wb_entry_t          head;

    logic ev_req, rd_req, rd_idle, rd_ok, ev_ok, ev_acc, rd_acc;
    logic push, upd, pop, head_upd;
    logic rd_miss_acc, rd_need, rd_want, lc_done;
    logic issue_wb, issue_rd, head_busy, fill_hit;

    l1d_wb_cam_fifo #(
        .Depth (WB_DEPTH)
    ) u_fifo (
        .clk_i      (clk_in),
        .rst_ni     (rst_N_in),
        .push_i     (push),
        .upd_i      (upd),
        .pop_i      (pop),
        .addr_i     (hc_addr_in),
        .line_i     (hc_value_in),
        .hit_o      (hit),
        .hit_idx_o  (hit_idx),
        .hit_line_o (hit_line),
        .head_o     (head),
        .head_idx_o (head_idx),
        .full_o     (full)
    );

    always_comb begin
        ev_req  = hc_valid_in && hc_we_in;
        rd_req  = hc_valid_in && !hc_we_in;
        rd_idle = live_q && (state_q == R_IDLE);
`ifdef L1D_WB_FORWARD_EN
        rd_ok   = rd_idle;
`else
        rd_ok   = rd_idle && !hit;
`endif
        rd_acc      = rd_req && rd_ok;
        rd_miss_acc = rd_req && rd_idle && !hit;
        rd_need     = (state_q == R_REQ) && !(lc_valid_q && !lc_we_q);
        rd_want     = rd_need || rd_miss_acc;
        lc_done     = lc_valid_q && lc_ready_in;
        // A full FIFO drains ahead of a pending read so evictions keep flowing.
        issue_wb    = !lc_valid_q && head.valid && (full || !rd_want);
        issue_rd    = !lc_valid_q && rd_want && !issue_wb;
        head_busy   = lc_valid_q && lc_we_q;
        ev_ok       = live_q && (hit ? !(hit_idx == head_idx && head_busy) : !full);
        ev_acc      = ev_req && ev_ok;
        push        = ev_acc && !hit;
        upd         = ev_acc && hit;
        head_upd    = upd && (hit_idx == head_idx);
        pop         = lc_done && lc_we_q;
        fill_hit    = (state_q == R_WAIT) && lc_valid_in && line_match(lc_addr_in, rd_addr_q);
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            R_IDLE:  if (rd_acc) state_d = hit ? R_FWD : R_REQ;
            R_FWD:   state_d = R_RESP;
            R_REQ:   if (lc_done && !lc_we_q) state_d = R_WAIT;
            R_WAIT:  if (fill_hit) state_d = R_RESP;
            R_RESP:  if (hc_ready_in) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        hc_ready_out = hc_we_in ? ev_ok : rd_ok;
        hc_valid_out = (state_q == R_RESP);
        lc_ready_out = (state_q == R_WAIT);
    end

    assign hc_addr_out  = resp_addr_q;
    assign hc_value_out = resp_line_q;
    assign lc_valid_out = lc_valid_q;
    assign lc_we_out    = lc_we_q;
    assign lc_addr_out  = lc_addr_q;
    assign lc_value_out = lc_value_q;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            live_q      <= 1'b0;
            rd_addr_q   <= '0;
            resp_addr_q <= '0;
            resp_line_q <= '0;
            lc_valid_q  <= 1'b0;
            lc_we_q     <= 1'b0;
            lc_addr_q   <= '0;
            lc_value_q  <= '0;
        end else begin
            live_q <= 1'b1;
            if (lc_done) begin
                lc_valid_q <= 1'b0;
            end
            if (issue_wb) begin
                lc_valid_q <= 1'b1;
                lc_we_q    <= 1'b1;
                lc_addr_q  <= head.paddr;
                // Coalescing into the head as it is launched must carry the new data.
                lc_value_q <= head_upd ? hc_value_in : head.line;
            end else if (issue_rd) begin
                lc_valid_q <= 1'b1;
                lc_we_q    <= 1'b0;
                lc_addr_q  <= rd_need ? rd_addr_q : hc_addr_in;
                lc_value_q <= '0;
            end
            if (rd_acc) begin
                rd_addr_q   <= hc_addr_in;
                resp_addr_q <= hc_addr_in;
                if (hit) begin
                    resp_line_q <= hit_line;
                end
            end
            if (fill_hit) begin
                resp_line_q <= lc_value_in;
            end
        end
    end

    a_no_evict_pending_read: assert property (@(posedge clk_in) disable iff (!rst_N_in)
        (ev_acc && (state_q == R_REQ || state_q == R_WAIT)) |->
        !line_match(hc_addr_in, rd_addr_q));

endmodule

// File: tb/tb_l1d_writeback_buffer.sv
// Directed bench for l1d_writeback_buffer with L2-request and fill scoreboards.
// Covers both builds of L1D_WB_FORWARD_EN.
module tb_l1d_writeback_buffer;

    logic         clk = 1'b0;
    logic         rst_N_in = 1'b0;
    logic         hc_valid_in = 1'b0, hc_we_in = 1'b0, hc_ready_in = 1'b0;
    logic [21:0]  hc_addr_in = '0;
    logic [511:0] hc_value_in = '0;
    logic         hc_ready_out, hc_valid_out;
    logic [21:0]  hc_addr_out;
    logic [511:0] hc_value_out;
    logic         lc_valid_out, lc_we_out, lc_ready_out;
    logic         lc_ready_in = 1'b0, lc_valid_in = 1'b0;
    logic [21:0]  lc_addr_out, lc_addr_in = '0;
    logic [511:0] lc_value_out, lc_value_in = '0;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {logic we; logic [21:0] addr; logic [511:0] val;} lc_t;
    typedef struct packed {logic [21:0] addr; logic [511:0] val;} hc_t;
    lc_t lc_exp[$];
    hc_t hc_exp[$];

    always #5 clk = ~clk;

    l1d_writeback_buffer dut (
        .clk_in       (clk),
        .rst_N_in     (rst_N_in),
        .hc_valid_in  (hc_valid_in),
        .hc_ready_out (hc_ready_out),
        .hc_addr_in   (hc_addr_in),
        .hc_value_in  (hc_value_in),
        .hc_we_in     (hc_we_in),
        .hc_valid_out (hc_valid_out),
        .hc_ready_in  (hc_ready_in),
        .hc_addr_out  (hc_addr_out),
        .hc_value_out (hc_value_out),
        .lc_valid_out (lc_valid_out),
        .lc_ready_in  (lc_ready_in),
        .lc_addr_out  (lc_addr_out),
        .lc_value_out (lc_value_out),
        .lc_we_out    (lc_we_out),
        .lc_valid_in  (lc_valid_in),
        .lc_ready_out (lc_ready_out),
        .lc_addr_in   (lc_addr_in),
        .lc_value_in  (lc_value_in)
    );

    function automatic logic [511:0] mk(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_hc_ready"}, hc_ready_out, 1'b0);
        chk1({tag, "_hc_valid"}, hc_valid_out, 1'b0);
        chk1({tag, "_lc_valid"}, lc_valid_out, 1'b0);
        chk1({tag, "_lc_ready"}, lc_ready_out, 1'b0);
        chk1({tag, "_lc_we"}, lc_we_out, 1'b0);
        chka({tag, "_lc_addr"}, lc_addr_out, 22'h0);
        chkl({tag, "_lc_value"}, lc_value_out, 512'h0);
        chka({tag, "_hc_addr"}, hc_addr_out, 22'h0);
        chkl({tag, "_hc_value"}, hc_value_out, 512'h0);
    endtask

    // Present one L1D request and hold it until accepted (bounded).
    task automatic send(input logic we, input logic [21:0] a, input logic [511:0] d,
                        input string tag);
        int n = 0;
        hc_valid_in = 1'b1;
        hc_we_in    = we;
        hc_addr_in  = a;
        hc_value_in = d;
        #1;
        while (hc_ready_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk1(tag, hc_ready_out, 1'b1);
        @(negedge clk);
        hc_valid_in = 1'b0;
    endtask

    task automatic drive_fill(input logic [21:0] a, input logic [511:0] d);
        int n = 0;
        lc_valid_in = 1'b1;
        lc_addr_in  = a;
        lc_value_in = d;
        #1;
        while (lc_ready_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk1("fill_accepted", lc_ready_out, 1'b1);
        @(negedge clk);
        lc_valid_in = 1'b0;
    endtask

    // Wait for the next L2 request, score it, accept it after lat cycles,
    // and for reads optionally return a fill (preceded by a foreign-line fill).
    task automatic l2_step(input int lat, input int fdly, input bit fill_en, input bit junk,
                           input logic [511:0] fill);
        int  n = 0;
        lc_t e;
        while (lc_valid_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("lc_req_seen", lc_valid_out, 1'b1);
        if (lc_valid_out !== 1'b1) return;
        e = 'x;
        if (lc_exp.size() != 0) e = lc_exp.pop_front();
        chk1("lc_we", lc_we_out, e.we);
        chka("lc_addr", lc_addr_out, e.addr);
        chkl("lc_value", lc_value_out, e.val);
        repeat (lat) @(negedge clk);
        chk1("lc_held", lc_valid_out, 1'b1);
        lc_ready_in = 1'b1;
        @(negedge clk);
        lc_ready_in = 1'b0;
        if (fill_en) begin
            repeat (fdly) @(negedge clk);
            if (junk) drive_fill(e.addr ^ 22'h40, ~fill);
            drive_fill(e.addr, fill);
        end
    endtask

    task automatic hc_step();
        int  n = 0;
        hc_t e;
        while (hc_valid_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("hc_valid", hc_valid_out, 1'b1);
        e = 'x;
        if (hc_exp.size() != 0) e = hc_exp.pop_front();
        chka("hc_addr", hc_addr_out, e.addr);
        chkl("hc_value", hc_value_out, e.val);
        hc_ready_in = 1'b1;
        @(negedge clk);
        hc_ready_in = 1'b0;
        chk1("hc_valid_drop", hc_valid_out, 1'b0);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (lc_valid_out !== 1'b0) seen++;
        end
        nvec++;
        assert (seen == 0) else begin
            nerr++;
            $error("FAIL %s: got %0d busy cycles want 0", tag, seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_N_in = 1'b1;
        repeat (2) @(negedge clk);

        // Read bypasses a parked eviction; fill returns after 3 cycles.
        lc_exp.push_back('{we: 1'b0, addr: 22'h2000, val: 512'h0});
        lc_exp.push_back('{we: 1'b1, addr: 22'h1000, val: mk(8'hAA)});
        hc_exp.push_back('{addr: 22'h2000, val: mk(8'h55)});
        send(1'b1, 22'h1000, mk(8'hAA), "t1_evict_acc");
        send(1'b0, 22'h2000, 512'h0, "t1_read_acc");
        l2_step(0, 3, 1'b1, 1'b0, mk(8'h55));
        hc_step();
        l2_step(0, 0, 1'b0, 1'b0, 512'h0);
        quiet(8, "t1_idle");

        // Back-to-back evictions of one line coalesce into a single writeback.
        lc_exp.push_back('{we: 1'b1, addr: 22'h1000, val: mk(8'hBB)});
        send(1'b1, 22'h1000, mk(8'hA1), "t2_evict_a");
        send(1'b1, 22'h1000, mk(8'hBB), "t2_evict_b");
        l2_step(1, 0, 1'b0, 1'b0, 512'h0);
        quiet(10, "t2_single_wb");

        // Read of a line still parked in the buffer.
        send(1'b1, 22'h1000, mk(8'hA2), "t3_evict");
`ifdef L1D_WB_FORWARD_EN
        lc_exp.push_back('{we: 1'b1, addr: 22'h1000, val: mk(8'hA2)});
        hc_exp.push_back('{addr: 22'h1000, val: mk(8'hA2)});
        send(1'b0, 22'h1000, 512'h0, "t3_read_acc");
        chk1("t3_fwd_cyc1", hc_valid_out, 1'b0);
        @(negedge clk);
        chk1("t3_fwd_cyc2", hc_valid_out, 1'b1);
        hc_step();
        l2_step(0, 0, 1'b0, 1'b0, 512'h0);
        quiet(10, "t3_no_l2_read");
`else
        lc_exp.push_back('{we: 1'b1, addr: 22'h1000, val: mk(8'hA2)});
        lc_exp.push_back('{we: 1'b0, addr: 22'h1000, val: 512'h0});
        hc_exp.push_back('{addr: 22'h1000, val: mk(8'hD4)});
        hc_valid_in = 1'b1;
        hc_we_in    = 1'b0;
        hc_addr_in  = 22'h1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("t3_read_stalled", hc_ready_out, 1'b0);
            @(negedge clk);
        end
        l2_step(0, 0, 1'b0, 1'b0, 512'h0);
        send(1'b0, 22'h1000, 512'h0, "t3_read_acc");
        l2_step(0, 2, 1'b1, 1'b0, mk(8'hD4));
        hc_step();
`endif

        // Fill the FIFO behind a stuck writeback; the pending read waits for the head.
        lc_exp.push_back('{we: 1'b1, addr: 22'h0, val: mk(8'h10)});
        lc_exp.push_back('{we: 1'b0, addr: 22'h200, val: 512'h0});
        lc_exp.push_back('{we: 1'b1, addr: 22'h40, val: mk(8'h11)});
        lc_exp.push_back('{we: 1'b1, addr: 22'h80, val: mk(8'h12)});
        lc_exp.push_back('{we: 1'b1, addr: 22'hC0, val: mk(8'h13)});
        hc_exp.push_back('{addr: 22'h200, val: mk(8'hE5)});
        send(1'b1, 22'h0, mk(8'h10), "t4_evict0");
        send(1'b1, 22'h40, mk(8'h11), "t4_evict1");
        send(1'b1, 22'h80, mk(8'h12), "t4_evict2");
        send(1'b1, 22'hC0, mk(8'h13), "t4_evict3");
        hc_valid_in = 1'b1;
        hc_we_in    = 1'b1;
        hc_addr_in  = 22'h100;
        hc_value_in = mk(8'h14);
        #1;
        chk1("t4_full_stall", hc_ready_out, 1'b0);
        @(negedge clk);
        #1;
        chk1("t4_full_stall2", hc_ready_out, 1'b0);
        @(negedge clk);
        hc_valid_in = 1'b0;
        send(1'b0, 22'h200, 512'h0, "t4_read_acc");
        l2_step(2, 0, 1'b0, 1'b0, 512'h0);
        l2_step(0, 2, 1'b1, 1'b1, mk(8'hE5));
        hc_step();
        l2_step(0, 0, 1'b0, 1'b0, 512'h0);
        l2_step(1, 0, 1'b0, 1'b0, 512'h0);
        l2_step(0, 0, 1'b0, 1'b0, 512'h0);
        quiet(6, "t4_drained");

        // Reset while waiting for a fill with two evictions parked.
        lc_exp.push_back('{we: 1'b0, addr: 22'h400, val: 512'h0});
        send(1'b0, 22'h400, 512'h0, "t5_read_acc");
        send(1'b1, 22'h300, mk(8'h30), "t5_evict0");
        send(1'b1, 22'h340, mk(8'h31), "t5_evict1");
        l2_step(0, 0, 1'b0, 1'b0, 512'h0);
        @(negedge clk);
        chk1("t5_waiting", lc_ready_out, 1'b1);
        rst_N_in = 1'b0;
        #1;
        chk_all_zero("t5_async_rst");
        repeat (2) @(negedge clk);
        rst_N_in = 1'b1;
        quiet(10, "t5_flushed");
        lc_exp.push_back('{we: 1'b0, addr: 22'h40, val: 512'h0});
        hc_exp.push_back('{addr: 22'h40, val: mk(8'h77)});
        send(1'b0, 22'h40, 512'h0, "t5_read_acc2");
        l2_step(0, 1, 1'b1, 1'b0, mk(8'h77));
        hc_step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/l1d_writeback_buffer.md
Name: l1d_writeback_buffer

Overview:
Sits between the L1 data cache's lower-cache port and the L2. It merges L1D read-miss requests and dirty-line evictions onto one L2 request channel. Evictions are parked in a small CAM-searchable FIFO so read misses can bypass them. A read miss to a line still parked in the buffer is answered locally.

Parameters:
B, 64, cache line size in bytes
PADDR_BITS, 22, physical address width
WB_DEPTH, 4, writeback FIFO entries (power of two, ≥2)

Ports:
clk_in  in  1  clock
rst_N_in  in  1  reset
hc_valid_in  in  1  L1D request valid
hc_ready_out  out  1  request accepted when high with hc_valid_in
hc_addr_in  in  PADDR_BITS  request address (line-aligned)
hc_value_in  in  8*B  eviction line data
hc_we_in  in  1  1 = eviction, 0 = read miss
hc_valid_out  out  1  fill response valid
hc_ready_in  in  1  L1D accepts fill
hc_addr_out  out  PADDR_BITS  fill address
hc_value_out  out  8*B  fill line
lc_valid_out  out  1  L2 request valid
lc_ready_in  in  1  L2 accepts request
lc_addr_out  out  PADDR_BITS  L2 request address
lc_value_out  out  8*B  writeback data (0 for reads)
lc_we_out  out  1  1 = writeback
lc_valid_in  in  1  L2 fill valid
lc_ready_out  out  1  fill accepted
lc_addr_in  in  PADDR_BITS  fill address
lc_value_in  in  8*B  fill data

Behaviour:
- Clock and reset: single clock clk_in. Reset rst_N_in is asynchronous and active-low.
- Reset values: every output is 0. The FIFO is emptied and the read FSM returns to R_IDLE.
- Reset mid-operation: in-flight and parked data is discarded. lc_valid_out and hc_valid_out drop asynchronously.
- Line match: compare bits [PADDR_BITS-1:$clog2(B)] only.
- Read FSM states: R_IDLE, R_FWD, R_REQ, R_WAIT, R_RESP.
- Eviction accept: hc_ready_out = !full || cam_hit.
  - On cam_hit, the matching entry's data is overwritten in place (coalesce); the count is unchanged.
  - Otherwise the eviction is pushed at the tail.
- Read accept: hc_ready_out = (state == R_IDLE).
  - On cam_hit → R_FWD. The matching line is copied into the response register.
  - Otherwise → R_REQ.
- R_FWD: always → R_RESP next cycle. hc_valid_out is asserted 2 cycles after accept.
- R_REQ: drives a read request (lc_we_out = 0). On lc_ready_in → R_WAIT.
- R_WAIT: lc_ready_out = 1.
  - On lc_valid_in with a matching line, the fill is latched → R_RESP.
  - A non-matching fill is accepted and dropped.
- R_RESP: hc_valid_out = 1 with the registered address and line. On hc_ready_in → R_IDLE.
- L2 arbitration (registered lc_* outputs, held stable until lc_ready_in):
  - A pending read (R_REQ) beats a FIFO-head writeback, unless the FIFO is full. Then the head drains first.
  - A transaction in progress is never preempted.
  - A writeback pops on lc_ready_in. No response is expected.
- Simultaneous push and pop: the count is unchanged. A coalesce into the head entry while that entry is being presented is stalled (hc_ready_out = 0) for that cycle.
- Illegal (asserted, not handled): an eviction of a line whose read is in R_REQ/R_WAIT.
- Pointer wrap: modulo WB_DEPTH. full = (count == WB_DEPTH).

Optional Feature:
L1D_WB_FORWARD_EN
- Defined: read cam_hit is served via R_FWD as above.
- Undefined: a read with cam_hit is refused (hc_ready_out = 0) until that entry has drained to L2. The read then goes to L2 normally, and R_FWD is unreachable.

Decomposition:
- Package l1d_wb_pkg holds:
  - wb_entry_t {paddr, line, valid}
  - rd_state_t enum
  - the LINE_OFF = $clog2(B) constant
- Sub-module l1d_wb_cam_fifo holds the FIFO storage, pointers, count, the parallel line-match (hit, hit_idx), in-place update, and push/pop.
- The top level holds the read FSM, arbitration and output registers.

Test Plan:
- Evict 0x1000 (line 0xAA..), then read 0x2000 with L2 returning 0x55.. after 3 cycles → the L2 sees the read first. Fill 0x55.. reaches hc_value_out, then the writeback of 0x1000 is issued.
- Evict 0x1000 twice (data A then B) → count = 1. Exactly one L2 writeback, carrying B.
- Evict 0x1000 (A), then read 0x1000 → with the macro: hc_valid_out 2 cycles after accept with data A, no L2 read. Without it: the read stalls until the writeback completes, then an L2 read is issued.
- Four evictions 0x0, 0x40, 0x80, 0xC0 with lc_ready_in = 0, then a fifth eviction 0x100 → hc_ready_out = 0. A read held pending → after lc_ready_in rises, 0x0 drains before the read.
- Assert rst_N_in low mid-R_WAIT with 2 parked evictions → all outputs are 0 immediately. After release there are no L2 requests, and a new read to 0x40 goes to L2.
